// File: rtl/crt_modectl.sv
// Sync-timing recogniser: learns hsync/vsync polarity, measures the line period and
// lines per frame, and locks onto one of three horizontal scan classes.
module crt_modectl #(
    parameter int unsigned STABLE_N = 8,
    parameter int unsigned MISS_N   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       onemks,
    input  logic       hsync,
    input  logic       vsync,
    output logic       locked,
    output logic [1:0] mode,
    output logic [7:0] hperiod,
    output logic [9:0] vlines,
    output logic       hpol,
    output logic       vpol
);

    typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

    state_e     state_q;
    logic [3:0] hpc_q, vpc_q, scnt_q;
    logic       hsync_q, hn_q, vn_q;
    logic [7:0] hcnt_q, hlast_q;
    logic [9:0] lcnt_q, fref_q;
    logic       fref_vld_q;
    logic [1:0] pcls_q, scls_q;

    logic       hn, vn, hedge, vedge, hrise, timeout;
    logic [1:0] cls;
    logic [9:0] fdiff;
    logic       frame_ok, verify_fail, locked_miss, go_search;
    logic [7:0] per_now;

    assign hpol = hpc_q[3];
    assign vpol = vpc_q[3];

    always_comb begin
        hn      = hsync ^ hpol;
        vn      = vsync ^ vpol;
        hedge   = hn & ~hn_q;
        vedge   = vn & ~vn_q;
        hrise   = hsync & ~hsync_q;
        timeout = (hcnt_q == 8'd255);

        cls = 2'd0;
        if (hcnt_q >= 8'd56 && hcnt_q <= 8'd72) begin
            cls = 2'd1;
        end else if (hcnt_q >= 8'd36 && hcnt_q <= 8'd44) begin
            cls = 2'd2;
        end else if (hcnt_q >= 8'd28 && hcnt_q <= 8'd35) begin
            cls = 2'd3;
        end

        fdiff    = (lcnt_q >= fref_q) ? (lcnt_q - fref_q) : (fref_q - lcnt_q);
        frame_ok = (fdiff <= 10'd2) && (lcnt_q >= 10'd200) && (lcnt_q <= 10'd700);
        // A line edge coinciding with the lock decision supplies the freshest period.
        per_now  = hedge ? hcnt_q : hlast_q;

        verify_fail = (state_q == StVerify) &&
                      ((hedge && cls != scls_q) || (vedge && fref_vld_q && !frame_ok));
        locked_miss = (state_q == StLocked) && hedge && (cls != mode) &&
                      (scnt_q == 4'(MISS_N - 1));
        go_search   = timeout || verify_fail || locked_miss;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StSearch;
            hpc_q      <= 4'b1000;
            vpc_q      <= 4'b1000;
            scnt_q     <= 4'd0;
            hsync_q    <= 1'b0;
            hn_q       <= 1'b0;
            vn_q       <= 1'b0;
            hcnt_q     <= 8'd0;
            hlast_q    <= 8'd0;
            lcnt_q     <= 10'd0;
            fref_q     <= 10'd0;
            fref_vld_q <= 1'b0;
            pcls_q     <= 2'd0;
            scls_q     <= 2'd0;
            locked     <= 1'b0;
            mode       <= 2'd0;
            hperiod    <= 8'd0;
            vlines     <= 10'd0;
        end else begin
            if (onemks) begin
                if (hsync && hpc_q != 4'd15) begin
                    hpc_q <= hpc_q + 4'd1;
                end else if (!hsync && hpc_q != 4'd0) begin
                    hpc_q <= hpc_q - 4'd1;
                end
            end
            if (hrise) begin
                if (vsync && vpc_q != 4'd15) begin
                    vpc_q <= vpc_q + 4'd1;
                end else if (!vsync && vpc_q != 4'd0) begin
                    vpc_q <= vpc_q - 4'd1;
                end
            end

            hsync_q <= hsync;
            hn_q    <= hn;
            vn_q    <= vn;

            if (hedge) begin
                hcnt_q  <= {7'd0, onemks};
                hlast_q <= hcnt_q;
                pcls_q  <= cls;
            end else if (onemks && !timeout) begin
                hcnt_q <= hcnt_q + 8'd1;
            end

            if (vedge) begin
                lcnt_q <= {9'd0, hedge};
            end else if (hedge && lcnt_q != 10'd1023) begin
                lcnt_q <= lcnt_q + 10'd1;
            end

            if (go_search) begin
                state_q <= StSearch;
                locked  <= 1'b0;
                mode    <= 2'd0;
                scnt_q  <= 4'd0;
            end else begin
                unique case (state_q)
                    StSearch: begin
                        if (hedge) begin
                            if (cls != 2'd0 && cls == pcls_q) begin
                                if (scnt_q == 4'(STABLE_N - 1)) begin
                                    state_q    <= StVerify;
                                    scls_q     <= cls;
                                    fref_q     <= 10'd0;
                                    fref_vld_q <= 1'b0;
                                    scnt_q     <= 4'd0;
                                end else begin
                                    scnt_q <= scnt_q + 4'd1;
                                end
                            end else begin
                                scnt_q <= 4'd0;
                            end
                        end
                    end
                    StVerify: begin
                        if (vedge) begin
                            if (!fref_vld_q) begin
                                fref_q     <= lcnt_q;
                                fref_vld_q <= 1'b1;
                            end else begin
                                state_q <= StLocked;
                                mode    <= scls_q;
                                hperiod <= per_now;
                                vlines  <= lcnt_q;
                                locked  <= 1'b1;
                                scnt_q  <= 4'd0;
                            end
                        end
                    end
                    StLocked: begin
                        if (hedge) begin
                            if (cls == mode) begin
                                scnt_q  <= 4'd0;
                                hperiod <= hcnt_q;
                            end else begin
                                scnt_q <= scnt_q + 4'd1;
                            end
                        end
                        if (vedge) begin
                            vlines <= lcnt_q;
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crt_modectl.sv
// Directed bench for crt_modectl: a line/frame sync generator with hand-derived
// lock points (line numbers) for 15 kHz, 25 kHz and 31 kHz timings.
module tb_crt_modectl;

    logic       clk = 1'b0;
    logic       reset;
    logic       onemks;
    logic       hsync, vsync;
    logic       locked;
    logic [1:0] mode;
    logic [7:0] hperiod;
    logic [9:0] vlines;
    logic       hpol, vpol;

    int n_checks = 0;
    int n_errors = 0;

    // Sync generator controls; one clock equals one microsecond (onemks held high).
    bit gen_on   = 1'b0;
    bit hact_low = 1'b1;
    bit vact_low = 1'b1;
    int hper     = 64;
    int fl_a     = 262;
    int fl_b     = 262;
    int lidx     = 0;
    bit fpar     = 1'b0;
    int line_no  = -1;

    crt_modectl #(
        .STABLE_N(8),
        .MISS_N  (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .onemks (onemks),
        .hsync  (hsync),
        .vsync  (vsync),
        .locked (locked),
        .mode   (mode),
        .hperiod(hperiod),
        .vlines (vlines),
        .hpol   (hpol),
        .vpol   (vpol)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits until line n has started and its edge has been processed, then settles.
    task automatic go_line(input int n, input int settle);
        int guard = 0;
        while (line_no < n && guard < 40000) begin
            tick(1);
            guard++;
        end
        check_eq($sformatf("reach_line_%0d", n), line_no, n);
        tick(settle);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_locked"}, locked, 0);
        check_eq({tag, "_mode"}, mode, 0);
        check_eq({tag, "_hperiod"}, hperiod, 0);
        check_eq({tag, "_vlines"}, vlines, 0);
        check_eq({tag, "_hpol"}, hpol, 1);
        check_eq({tag, "_vpol"}, vpol, 1);
    endtask

    // Line generator: 5 us sync pulse at line start, vsync active on lines 0..2 of a frame.
    initial begin
        int cur;
        forever begin
            if (!gen_on) begin
                @(negedge clk);
            end else begin
                line_no++;
                cur   = hper;
                hsync = hact_low ? 1'b0 : 1'b1;
                vsync = (lidx < 3) ? ~vact_low : vact_low;
                repeat (5) @(negedge clk);
                hsync = hact_low ? 1'b1 : 1'b0;
                repeat (cur - 5) @(negedge clk);
                lidx++;
                if (lidx >= (fpar ? fl_b : fl_a)) begin
                    lidx = 0;
                    fpar = ~fpar;
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        onemks = 1'b1;
        hsync  = 1'b1;
        vsync  = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(10);

        // 15 kHz, active-low: first vsync at line 5, VERIFY after line 9, ref at 267, lock at 529.
        lidx   = 257;
        gen_on = 1'b1;
        go_line(528, 3);
        check_eq("a_prelock", locked, 0);
        go_line(529, 3);
        check_eq("a_locked", locked, 1);
        check_eq("a_mode", mode, 1);
        check_eq("a_hperiod", hperiod, 64);
        check_eq("a_vlines", vlines, 262);
        check_eq("a_hpol", hpol, 1);
        check_eq("a_vpol", vpol, 1);

        // Switch to 40 us lines (from line 530) and 210-line frames: 531..533 miss, 534 drops.
        hper = 40;
        fl_a = 210;
        fl_b = 210;
        go_line(531, 3);
        check_eq("b_miss1_locked", locked, 1);
        check_eq("b_miss1_hperiod", hperiod, 64);
        go_line(533, 3);
        check_eq("b_miss3_locked", locked, 1);
        check_eq("b_miss3_mode", mode, 1);
        go_line(534, 3);
        check_eq("b_drop_locked", locked, 0);
        check_eq("b_drop_mode", mode, 0);
        check_eq("b_drop_hperiod", hperiod, 64);
        // VERIFY after line 542, ref at 739, relock at 949.
        go_line(948, 3);
        check_eq("b_prelock", locked, 0);
        go_line(949, 3);
        check_eq("b_locked", locked, 1);
        check_eq("b_mode", mode, 2);
        check_eq("b_hperiod", hperiod, 40);
        check_eq("b_vlines", vlines, 210);

        // Stop hsync after line 950: lock lost 255 cycles after that edge.
        go_line(950, 0);
        gen_on = 1'b0;
        tick(253);
        check_eq("c_still_locked", locked, 1);
        tick(4);
        check_eq("c_timeout_locked", locked, 0);
        check_eq("c_timeout_mode", mode, 0);
        check_eq("c_hold_hperiod", hperiod, 40);
        check_eq("c_hold_vlines", vlines, 210);
        tick(60);

        // 31 kHz, active-high, frames 200/204: ref 12 -> fail at 212, ref 204 -> fail at 616.
        // Second frame length becomes 201 from line 420: ref 201 at 817, lock at 1017.
        hact_low = 1'b0;
        vact_low = 1'b0;
        hper     = 32;
        fl_a     = 200;
        fl_b     = 204;
        lidx     = 192;
        fpar     = 1'b1;
        line_no  = -1;
        gen_on   = 1'b1;
        go_line(212, 3);
        check_eq("d_partial_ref_locked", locked, 0);
        go_line(420, 0);
        fl_b = 201;
        go_line(616, 3);
        check_eq("d_204_200_locked", locked, 0);
        check_eq("d_204_200_mode", mode, 0);
        go_line(1016, 3);
        check_eq("d_prelock", locked, 0);
        go_line(1017, 3);
        check_eq("d_locked", locked, 1);
        check_eq("d_mode", mode, 3);
        check_eq("d_hperiod", hperiod, 32);
        check_eq("d_vlines", vlines, 200);
        check_eq("d_hpol", hpol, 0);
        check_eq("d_vpol", vpol, 0);

        // Asynchronous reset mid-line while locked.
        tick(7);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midline_reset");
        gen_on = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(5);
        check_eq("post_reset_locked", locked, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
